// File: rtl/matrix_memory.sv
// Playfield store for the matrix-memory write interface: OR-merges 4x4 shapes
// into the board, removes full rows, and serves combinational window/row reads.
package matrix_memory_pkg;
    typedef struct packed {
        logic signed [7:0] x;
        logic signed [7:0] y;
    } point_t;
endpackage

module matrix_memory
    import matrix_memory_pkg::*;
#(
    parameter int width_p  = 16,
    parameter int height_p = 32
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        clear_i,
    input  point_t                      mm_write_addr_i,
    input  logic [3:0][3:0]             mm_write_data_i,
    input  logic                        mm_write_v_i,
    output logic                        mm_is_ready_o,
    input  point_t                      rd_addr_i,
    output logic [3:0][3:0]             rd_data_o,
    input  logic [$clog2(height_p)-1:0] disp_row_i,
    output logic [width_p-1:0]          disp_data_o,
    output logic                        lines_v_o,
    output logic [2:0]                  lines_o
);
    localparam int RW = $clog2(height_p);
    localparam int CW = $clog2(width_p);

    typedef enum logic [1:0] {eIDLE, eMERGE, eSCAN, eDONE} state_e;

    state_e                           r_state;
    logic [height_p-1:0][width_p-1:0] r_board;
    point_t                           r_addr;
    logic [3:0][3:0]                  r_data;
    logic [1:0]                       r_cnt;
    logic [RW-1:0]                    r_ptr;
    logic [2:0]                       r_lines;

    logic [width_p-1:0]               w_merge_mask;
    logic                             w_merge_row_ok;
    logic [RW-1:0]                    w_merge_row;
    logic                             w_row_full;

    // Shape row r_cnt placed at columns x..x+3; columns off the board drop out.
    always_comb begin
        int off;
        int row;
        off            = 0;
        row            = int'($signed(r_addr.y)) + int'(r_cnt);
        w_merge_mask   = '0;
        w_merge_row_ok = (row >= 0) && (row < height_p);
        w_merge_row    = row[RW-1:0];
        for (int j = 0; j < width_p; j++) begin
            off = j - int'($signed(r_addr.x));
            if (off >= 0 && off <= 3)
                w_merge_mask[j] = r_data[r_cnt][off[1:0]];
        end
    end

    assign w_row_full = &r_board[r_ptr];

    // Collision window: anything outside the board reads as occupied.
    always_comb begin
        int row;
        int col;
        row       = 0;
        col       = 0;
        rd_data_o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                row = int'($signed(rd_addr_i.y)) + r;
                col = int'($signed(rd_addr_i.x)) + c;
                if (row < 0 || row >= height_p || col < 0 || col >= width_p)
                    rd_data_o[r][c] = 1'b1;
                else
                    rd_data_o[r][c] = r_board[row[RW-1:0]][col[CW-1:0]];
            end
        end
    end

    assign disp_data_o   = r_board[disp_row_i];
    assign mm_is_ready_o = (r_state == eIDLE);
    assign lines_v_o     = (r_state == eDONE);
    assign lines_o       = lines_v_o ? r_lines : 3'd0;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            // NOTE: the board is a flop array, so wiping it in a single reset cycle is intended.
            r_board <= '0;
            r_state <= eIDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_lines <= '0;
        end else begin
            case (r_state)
                eIDLE: begin
                    if (clear_i) begin
                        r_board <= '0;
                    end else if (mm_write_v_i) begin
                        r_addr  <= mm_write_addr_i;
                        r_data  <= mm_write_data_i;
                        r_cnt   <= '0;
                        r_state <= eMERGE;
                    end
                end
                eMERGE: begin
                    if (w_merge_row_ok)
                        r_board[w_merge_row] <= r_board[w_merge_row] | w_merge_mask;
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        r_ptr   <= RW'(height_p - 1);
                        r_state <= eSCAN;
                    end
                end
                eSCAN: begin
                    // Pointer holds on a clear so the row that drops in gets rechecked.
                    if (w_row_full) begin
                        for (int i = 1; i < height_p; i++) begin
                            if (i <= int'(r_ptr))
                                r_board[i] <= r_board[i-1];
                        end
                        r_board[0] <= '0;
                        if (r_lines != 3'd7)
                            r_lines <= r_lines + 3'd1;
                    end else if (r_ptr == '0) begin
                        r_state <= eDONE;
                    end else begin
                        r_ptr <= r_ptr - RW'(1);
                    end
                end
                eDONE: begin
                    r_lines <= '0;
                    r_state <= eIDLE;
                end
                default: r_state <= eIDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_memory.sv
// Self-checking bench for matrix_memory: directed corner cases plus random
// commits compared against a row-list playfield model.
module tb_matrix_memory;
    import matrix_memory_pkg::*;

    localparam int W = 16;
    localparam int H = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            clear = 1'b0;
    logic            wv = 1'b0;
    point_t          waddr = '0;
    point_t          raddr = '0;
    logic [3:0][3:0] wdata = '0;
    logic [3:0][3:0] rdata;
    logic [4:0]      drow = '0;
    logic [15:0]     ddata;
    logic            ready;
    logic            lv;
    logic [2:0]      lines;

    always #5 clk = ~clk;

    matrix_memory #(.width_p(W), .height_p(H)) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .clear_i         (clear),
        .mm_write_addr_i (waddr),
        .mm_write_data_i (wdata),
        .mm_write_v_i    (wv),
        .mm_is_ready_o   (ready),
        .rd_addr_i       (raddr),
        .rd_data_o       (rdata),
        .disp_row_i      (drow),
        .disp_data_o     (ddata),
        .lines_v_o       (lv),
        .lines_o         (lines)
    );

    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] model [H];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_wipe();
        for (int i = 0; i < H; i++) model[i] = '0;
    endfunction

    // Merge the shape, then rebuild the board from the surviving rows bottom-up.
    function automatic void model_commit(input int x, input int y, input logic [3:0][3:0] d,
                                         output int k);
        logic [15:0] keep [$];
        int row, col;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                row = y + r;
                col = x + c;
                if (d[r][c] && row >= 0 && row < H && col >= 0 && col < W)
                    model[row][col] = 1'b1;
            end
        k = 0;
        for (int i = H - 1; i >= 0; i--)
            if (model[i] == 16'hFFFF) k++;
            else keep.push_back(model[i]);
        for (int i = H - 1; i >= 0; i--)
            model[i] = (keep.size() > 0) ? keep.pop_front() : 16'h0000;
    endfunction

    function automatic logic [15:0] model_rd(input int x, input int y);
        logic [15:0] v;
        int row, col;
        v = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                row = y + r;
                col = x + c;
                if (row < 0 || row >= H || col < 0 || col >= W) v[r*4+c] = 1'b1;
                else v[r*4+c] = model[row][col];
            end
        return v;
    endfunction

    task automatic check_board(input string tag);
        for (int i = 0; i < H; i++) begin
            drow = 5'(i);
            #1;
            check($sformatf("%s_row%0d", tag, i), ddata, model[i]);
        end
        tick();
    endtask

    task automatic check_rd(input string tag, input int x, input int y);
        raddr.x = 8'(x);
        raddr.y = 8'(y);
        #1;
        check(tag, rdata, model_rd(x, y));
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ready && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_wait_ready"}, ready, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_wipe();
    endtask

    task automatic commit(input int x, input int y, input logic [3:0][3:0] d, input bit noise,
                          input string tag, output int got_lines);
        int  k, n;
        bit  seen;
        wait_ready(tag);
        waddr.x = 8'(x);
        waddr.y = 8'(y);
        wdata   = d;
        wv      = 1'b1;
        tick();
        wv = 1'b0;
        model_commit(x, y, d, k);
        check({tag, "_busy"}, ready, 1'b0);
        n = 1;
        seen = 1'b0;
        got_lines = -1;
        while (n < 200) begin
            if (lv) begin
                seen = 1'b1;
                got_lines = int'(lines);
                break;
            end
            if (noise && n >= 12 && n <= 20) begin
                wv    = 1'b1;
                waddr = 16'($urandom);
                wdata = 16'($urandom);
            end else begin
                wv = 1'b0;
            end
            tick();
            n++;
        end
        wv = 1'b0;
        check({tag, "_done_seen"}, seen, 1'b1);
        check({tag, "_latency"}, n, 37 + k);
        check({tag, "_lines"}, lines, k);
        tick();
        check({tag, "_ready_after"}, ready, 1'b1);
        check({tag, "_pulse_one_cycle"}, lv, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int gl, pulses;
        model_wipe();
        tick();
        tick();
        reset = 1'b0;

        check("rst_ready", ready, 1'b1);
        check("rst_lines_v", lv, 1'b0);
        check("rst_lines", lines, 3'd0);
        check_rd("rst_rd_origin", 0, 0);
        check_rd("rst_rd_left_edge", -1, 0);
        check_board("rst");

        // Block at the bottom-left corner, no rows cleared.
        commit(0, 28, 16'hFFFF, 1'b0, "t1", gl);
        drow = 5'd31;
        #1;
        check("t1_row31_const", ddata, 16'h000F);
        check_board("t1");

        // Two pre-filled rows completed by the lower half of a shape.
        do_reset();
        commit(4, 30, 16'h00FF, 1'b0, "t2_fill_a", gl);
        commit(8, 30, 16'h00FF, 1'b0, "t2_fill_b", gl);
        commit(12, 30, 16'h00FF, 1'b0, "t2_fill_c", gl);
        commit(0, 28, 16'hFF00, 1'b0, "t2", gl);
        check("t2_lines_const", gl, 2);
        check_board("t2");

        // Shape hanging off the top-right corner.
        do_reset();
        commit(14, -2, 16'hFFFF, 1'b0, "t3", gl);
        drow = 5'd0;
        #1;
        check("t3_row0_const", ddata, 16'hC000);
        raddr.x = 8'd14;
        raddr.y = 8'd0;
        #1;
        check("t3_rd_const", rdata, 16'hCCFF);
        check_board("t3");

        // Reset in the middle of a merge.
        wait_ready("t4");
        waddr.x = 8'd0;
        waddr.y = 8'd28;
        wdata   = 16'hFFFF;
        wv      = 1'b1;
        tick();
        wv = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_wipe();
        check("t4_ready", ready, 1'b1);
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            if (lv) pulses++;
            tick();
        end
        check("t4_no_pulse", pulses, 0);
        check_board("t4");

        // Clear and write together in idle: clear wins.
        commit(3, 10, 16'h0F0F, 1'b0, "t5_pre", gl);
        waddr.x = 8'd0;
        waddr.y = 8'd0;
        wdata   = 16'hFFFF;
        wv      = 1'b1;
        clear   = 1'b1;
        tick();
        wv    = 1'b0;
        clear = 1'b0;
        model_wipe();
        check("t5_ready", ready, 1'b1);
        pulses = 0;
        for (int i = 0; i < 45; i++) begin
            if (lv || !ready) pulses++;
            tick();
        end
        check("t5_stays_idle", pulses, 0);
        check_board("t5");

        // Write requests during the scan are ignored.
        commit(5, 20, 16'h6996, 1'b1, "t6", gl);
        check_board("t6");

        // Random commits; dense shapes so full rows appear over time.
        for (int t = 0; t < 40; t++) begin
            int x, y;
            logic [15:0] d;
            x = int'($urandom_range(0, 19)) - 3;
            y = int'($urandom_range(0, 35)) - 3;
            d = 16'($urandom | $urandom);
            commit(x, y, d, bit'($urandom_range(0, 1)), $sformatf("rnd%0d", t), gl);
            check_board($sformatf("rnd%0d", t));
            check_rd($sformatf("rnd%0d_rd", t), int'($urandom_range(0, 19)) - 3,
                     int'($urandom_range(0, 35)) - 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
